// File: rtl/fpau_sched.sv
// ---------------------------------------------------------------------------
// fpau_sched -- in-order completion scheduler for an array of FP units.
//
// Accepts one FPU operation per cycle, issues it to the external unit whose
// index equals the op code, and keeps up to DEPTH operations in flight across
// different units. Results are parked in a completion buffer and retire
// strictly in issue order.
//
// Optional build macro: FPAU_SCHED_STATS_EN adds the stat_issued,
// stat_retired and stat_stall counters and their ports.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid/in_ready         operation handshake
//   in_op, in_x1, in_x2       op code (= unit index) and operands
//   in_tag                    caller tag, returned with the result
//   out_valid/out_ready       result handshake (head of completion buffer)
//   out_y32, out_y1           32-bit and 1-bit results
//   out_tag, out_err          tag of retiring op, op code was out of range
//   unit_start                one-cycle start pulse per unit
//   unit_x1, unit_x2          operands broadcast to all units
//   unit_done                 one-cycle completion pulse per unit
//   unit_y32, unit_y1         unit results, unit u at [32u+31:32u] / [u]
//   busy                      at least one buffer entry allocated
//   stat_issued/retired/stall (FPAU_SCHED_STATS_EN only) event counters
// ---------------------------------------------------------------------------
`ifndef FPU_OP_WIDTH
`define FPU_OP_WIDTH 4
`endif

module fpau_sched #(
  parameter int NUM_UNITS = 13,
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [`FPU_OP_WIDTH-1:0] in_op,
  input  logic [31:0]              in_x1,
  input  logic [31:0]              in_x2,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_y32,
  output logic                     out_y1,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err,
  output logic [NUM_UNITS-1:0]     unit_start,
  output logic [31:0]              unit_x1,
  output logic [31:0]              unit_x2,
  input  logic [NUM_UNITS-1:0]     unit_done,
  input  logic [NUM_UNITS*32-1:0]  unit_y32,
  input  logic [NUM_UNITS-1:0]     unit_y1,
  output logic                     busy
`ifdef FPAU_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_retired,
  output logic [31:0]              stat_stall
`endif
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int OPW = `FPU_OP_WIDTH;

  // Completion buffer entries
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_err;
  logic [DEPTH-1:0] r_y1;
  logic [OPW-1:0]   r_unit [DEPTH];
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic [31:0]      r_y32  [DEPTH];

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  // Per-unit occupancy and the buffer slot the unit will write back into
  logic [NUM_UNITS-1:0] r_unit_busy;
  logic [PW-1:0]        r_unit_ptr [NUM_UNITS];

  logic [NUM_UNITS-1:0] r_start;
  logic [31:0]          r_x1;
  logic [31:0]          r_x2;

  logic [NUM_UNITS-1:0] w_op_onehot;
  logic [NUM_UNITS-1:0] w_done_hit;
  logic                 w_op_ok;
  logic                 w_unit_free;
  logic                 w_not_full;
  logic                 w_accept;
  logic                 w_retire;

  // Decode op code to a unit one-hot; out-of-range codes decode to all zeros
  always_comb begin
    w_op_onehot = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (in_op == OPW'(u)) begin
        w_op_onehot[u] = 1'b1;
      end else begin
        w_op_onehot[u] = 1'b0;
      end
    end
  end

  assign w_op_ok     = |w_op_onehot;
  // An invalid op has an all-zero one-hot and therefore never waits on a unit
  assign w_unit_free = ~(|(w_op_onehot & r_unit_busy));
  assign w_not_full  = (r_count < CW'(DEPTH));
  assign in_ready    = rstn & w_not_full & w_unit_free;
  assign w_accept    = in_valid & in_ready;

  // Late completions from units that are not tracked as busy are dropped
  assign w_done_hit  = unit_done & r_unit_busy;

  assign out_valid = r_valid[r_head] & r_done[r_head];
  assign out_y32   = r_y32[r_head];
  assign out_y1    = r_y1[r_head];
  assign out_tag   = r_tag[r_head];
  assign out_err   = r_err[r_head];
  assign w_retire  = out_valid & out_ready;

  assign busy       = (r_count != CW'(0));
  assign unit_start = r_start;
  assign unit_x1    = r_x1;
  assign unit_x2    = r_x2;

  // Head/tail pointers and occupancy count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_retire) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Completion buffer: allocate at tail, write back on unit done, free at head
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_y1    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_unit[i] <= '0;
        r_tag[i]  <= '0;
        r_y32[i]  <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_retire && (r_head == PW'(i))) begin
          r_valid[i] <= 1'b0;
        end
        // Tail slot is free whenever accept is possible, so it never aliases
        // the head being retired or a slot awaiting a unit result.
        if (w_accept && (r_tail == PW'(i))) begin
          r_valid[i] <= 1'b1;
          r_done[i]  <= ~w_op_ok;
          r_err[i]   <= ~w_op_ok;
          r_unit[i]  <= in_op;
          r_tag[i]   <= in_tag;
          r_y32[i]   <= 32'h0000_0000;
          r_y1[i]    <= 1'b0;
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
          if (w_done_hit[u] && (r_unit_ptr[u] == PW'(i)) && (r_unit[i] == OPW'(u))) begin
            r_done[i] <= 1'b1;
            r_y32[i]  <= unit_y32[32*u +: 32];
            r_y1[i]   <= unit_y1[u];
          end
        end
      end
    end
  end

  // Unit occupancy: set on issue, cleared on that unit's done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_unit_busy <= '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        r_unit_ptr[u] <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (w_done_hit[u]) begin
          r_unit_busy[u] <= 1'b0;
        end else if (w_accept && w_op_onehot[u]) begin
          r_unit_busy[u] <= 1'b1;
          r_unit_ptr[u]  <= r_tail;
        end
      end
    end
  end

  // Issue stage: start pulse and operands presented one cycle after accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_start <= '0;
      r_x1    <= 32'h0000_0000;
      r_x2    <= 32'h0000_0000;
    end else begin
      if (w_accept && w_op_ok) begin
        r_start <= w_op_onehot;
        r_x1    <= in_x1;
        r_x2    <= in_x2;
      end else begin
        r_start <= '0;
      end
    end
  end

`ifdef FPAU_SCHED_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_retired;
  logic [31:0] r_stat_stall;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_issued  <= 32'h0000_0000;
      r_stat_retired <= 32'h0000_0000;
      r_stat_stall   <= 32'h0000_0000;
    end else begin
      if (w_accept) begin
        r_stat_issued <= r_stat_issued + 32'd1;
      end
      if (w_retire) begin
        r_stat_retired <= r_stat_retired + 32'd1;
      end
      if (in_valid && !in_ready) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_issued  = r_stat_issued;
  assign stat_retired = r_stat_retired;
  assign stat_stall   = r_stat_stall;
`endif

endmodule

// File: doc/fpau_sched.md
Name: fpau_sched

Overview:
Parametrised successor to the FPU arithmetic dispatcher. Accepts one FPU operation per cycle through a valid/ready input port. Issues each operation to one of NUM_UNITS external arithmetic units (fadd, fmul, finv, ...) and keeps up to DEPTH operations in flight across different units. Results retire strictly in issue order through a tagged valid/ready output port. The block sits between the core's FP issue stage and the unit array and replaces the single-op, single-outstanding dispatcher.

Parameters:
NUM_UNITS, 13, number of attached units; unit index = op code value
DEPTH, 4, completion-buffer entries = max in-flight ops (power of 2, >=2)
TAG_W, 4, width of the opaque tag carried from input to output

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  block accepts operation this cycle
in_op  in  `FPU_OP_WIDTH  op code = target unit index
in_x1  in  32  operand 1
in_x2  in  32  operand 2
in_tag  in  TAG_W  caller tag
out_valid  out  1  head result available
out_ready  in  1  consumer takes result
out_y32  out  32  32-bit result
out_y1  out  1  1-bit result (compare ops)
out_tag  out  TAG_W  tag of the retiring op
out_err  out  1  op code was >= NUM_UNITS
unit_start  out  NUM_UNITS  one-cycle start pulse per unit
unit_x1  out  32  operand 1, broadcast to all units
unit_x2  out  32  operand 2, broadcast to all units
unit_done  in  NUM_UNITS  one-cycle completion pulse per unit
unit_y32  in  NUM_UNITS*32  unit u result at bits [32u+31:32u]
unit_y1  in  NUM_UNITS  1-bit results
busy  out  1  at least one entry allocated

Behaviour:
- Reset (async, rstn=0): all entries invalid; head/tail pointers and count = 0; unit_busy = 0; unit_start = 0; unit_x1/unit_x2 = 0; out_valid = 0; out_y32/out_y1/out_tag/out_err = 0; busy = 0. in_ready = 0 while rstn = 0.
- Reset mid-operation discards all in-flight ops. A unit_done arriving after reset for a unit not marked busy is ignored.
- Entry fields: valid, done, err, unit index, tag, y32, y1.
- in_ready = rstn & (count < DEPTH) & (in_op >= NUM_UNITS | !unit_busy[in_op]). It uses registered state only: a retire or done in the same cycle does not free capacity until the next cycle.
- Accept (in_valid & in_ready) at cycle T:
  - Allocate the tail entry, record unit and tag, increment tail.
  - Set unit_busy[op] and unit_ptr[op] = tail.
  - Register operands so unit_start[op] pulses in cycle T+1 with unit_x1/unit_x2 valid in the same cycle.
- Invalid op (>= NUM_UNITS): entry is allocated with done=1, err=1, y32=0, y1=0 at the T edge. No unit_start is issued.
- unit_done[u] in cycle D with unit_busy[u] = 1:
  - Write unit_y32/y1 into entry unit_ptr[u] and set done.
  - Clear unit_busy[u] at the D edge, so a new issue to u is possible from D+1.
  - Multiple units may complete in the same cycle; all are captured.
- Output: out_* is driven from the head entry registers. out_valid = head.valid & head.done. Unit latency L gives out_valid earliest at cycle T+2+L.
- Retire (out_valid & out_ready): invalidate head, increment head. Wraps modulo DEPTH.
- Units completing out of order: a younger result waits in its buffer entry. out_* holds stable while out_valid & !out_ready.
- Issue and retire in the same cycle: count unchanged. Pointers wrap independently.
- busy = (count != 0).

Optional Feature:
FPAU_SCHED_STATS_EN
- Defined: adds outputs stat_issued (32), stat_retired (32) and stat_stall (32). stat_stall counts cycles with in_valid & !in_ready. All three are reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single op, bench unit 2 latency 3: accept op=2, tag=5, x1=0x3F800000 at T -> unit_start[2] at T+1, out_valid at T+5 with out_y32 = model result, out_tag=5.
- Reorder: op=4 (latency 6, tag 1) then op=2 (latency 1, tag 2) -> unit 2 done first, but out order is tag 1 then tag 2.
- Full: issue DEPTH=4 ops to distinct units, out_ready=0 -> 5th offer sees in_ready=0. Retire one -> in_ready=1 the following cycle. Pointers wrap correctly across 3 refills.
- Unit busy: two back-to-back op=2 -> second stalls until the cycle after unit_done[2].
- Invalid op=15 with NUM_UNITS=13 -> no unit_start, out_err=1, out_y32=0 at T+1 if at head.
- Reset with 3 ops in flight, then a late unit_done -> out_valid stays 0, busy=0, unit_busy=0, no entry written. With FPAU_SCHED_STATS_EN defined, all counters read 0 after reset.
